// File: rtl/reflex_pkg.sv
// Shared definitions for the reflex-trainer game sequencer.
// Provides the IDLE/GAME state encoding, the BCD digit width, a two-digit BCD
// struct and the default screen/ball geometry used by game_ctrl and
// ball_pos_lfsr.
package reflex_pkg;
  localparam int BCD_W      = 4;
  localparam int DEF_BALL_R = 16;
  localparam int DEF_H_MAX  = 640;
  localparam int DEF_V_MAX  = 480;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAME = 1'b1
  } game_st_e;

  typedef struct packed {
    logic [BCD_W-1:0] ten;
    logic [BCD_W-1:0] one;
  } bcd2_t;
endpackage

// File: rtl/ball_pos_lfsr.sv
// Pseudo-random ball placement.
// A 16-bit Fibonacci LFSR (taps 16,14,13,11) free-runs every cycle; its low
// bits are folded into the on-screen range so the whole ball stays visible.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset (LFSR <= LFSR_SEED)
//   next_x_o  candidate ball centre x from the current LFSR value
//   next_y_o  candidate ball centre y from the current LFSR value
module ball_pos_lfsr
  import reflex_pkg::*;
#(
  parameter int          BALL_R    = DEF_BALL_R,
  parameter int          H_MAX     = DEF_H_MAX,
  parameter int          V_MAX     = DEF_V_MAX,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] next_x_o,
  output logic [9:0] next_y_o
);
  localparam logic [9:0] X_RNG = 10'(H_MAX - 2*BALL_R);
  localparam logic [9:0] Y_RNG = 10'(V_MAX - 2*BALL_R);
  localparam logic [9:0] OFS   = 10'(BALL_R);

  logic [15:0] lfsr_q;
  logic        fb;

  // Taps 16,14,13,11 in 1-based numbering are bits 15,13,12,10.
  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[14:0], fb};
  end

  // One conditional subtract is enough: the source field is below 2*range.
  function automatic logic [9:0] fold(input logic [9:0] v, input logic [9:0] r);
    return (v >= r) ? (v - r) : v;
  endfunction

  assign next_x_o = OFS + fold(lfsr_q[9:0], X_RNG);
  assign next_y_o = OFS + fold({1'b0, lfsr_q[8:0]}, Y_RNG);
endmodule

// File: rtl/game_ctrl.sv
// Reflex-trainer game sequencer feeding the pixel generator.
// Owns the IDLE/GAME state, BCD countdown, BCD score, ball position and
// click/hit detection.
// Ports:
//   clk_25MHz, rst             clock, synchronous active-high reset
//   MOUSE_X_POS/MOUSE_Y_POS    cursor position
//   MOUSE_LEFT                 left button level (already synchronous)
//   start_hover                cursor is over the start button
//   game_state                 0=IDLE, 1=GAME
//   ball_x/ball_y              ball centre
//   time_ten/time_one          remaining seconds, BCD
//   score_ten/score_one        hits, BCD (saturates at 99)
//   new_best                   last round beat the stored best
// Optional feature macro: GAME_CTRL_BEST_SCORE_EN (best-score register and
// new_best star); when undefined new_best is tied low.
module game_ctrl
  import reflex_pkg::*;
#(
  parameter int          CLK_HZ    = 25_000_000,
  parameter int          GAME_SEC  = 30,
  parameter int          BALL_R    = DEF_BALL_R,
  parameter int          H_MAX     = DEF_H_MAX,
  parameter int          V_MAX     = DEF_V_MAX,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic [9:0] MOUSE_X_POS,
  input  logic [9:0] MOUSE_Y_POS,
  input  logic       MOUSE_LEFT,
  input  logic       start_hover,
  output logic       game_state,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] time_ten,
  output logic [3:0] time_one,
  output logic [3:0] score_ten,
  output logic [3:0] score_one,
  output logic       new_best
);
  localparam int              PS_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(CLK_HZ - 1);
  localparam bcd2_t           TIME_INIT = '{ten: BCD_W'(GAME_SEC / 10), one: BCD_W'(GAME_SEC % 10)};
  localparam bcd2_t           TIME_ONE  = '{ten: 4'd0, one: 4'd1};
  localparam logic signed [10:0] R_S    = 11'(BALL_R);

  game_st_e        state_q;
  logic            left_q;
  logic [PS_W-1:0] presc_q;
  bcd2_t           time_q;
  bcd2_t           score_q;
  bcd2_t           score_d;
  logic [9:0]      ball_x_q;
  logic [9:0]      ball_y_q;
  logic [9:0]      next_x;
  logic [9:0]      next_y;
  logic            click;
  logic            sec_tick;
  logic            hit;
  logic signed [10:0] dx;
  logic signed [10:0] dy;

  function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ten == 4'd9 && v.one == 4'd9) r = v;
    else if (v.one == 4'd9) begin
      r.one = 4'd0;
      r.ten = v.ten + 4'd1;
    end else r.one = v.one + 4'd1;
    return r;
  endfunction

  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.one == 4'd0) begin
      r.one = 4'd9;
      r.ten = v.ten - 4'd1;
    end else r.one = v.one - 4'd1;
    return r;
  endfunction

  function automatic logic in_box(input logic signed [10:0] d);
    return (d <= R_S) && (d >= -R_S);
  endfunction

  ball_pos_lfsr #(
    .BALL_R    (BALL_R),
    .H_MAX     (H_MAX),
    .V_MAX     (V_MAX),
    .LFSR_SEED (LFSR_SEED)
  ) u_pos (
    .clk_i    (clk_25MHz),
    .rst_i    (rst),
    .next_x_o (next_x),
    .next_y_o (next_y)
  );

  assign click    = MOUSE_LEFT & ~left_q;
  // Zero-extended 11-bit signed differences keep cursor-left-of-ball negative.
  assign dx       = $signed({1'b0, MOUSE_X_POS}) - $signed({1'b0, ball_x_q});
  assign dy       = $signed({1'b0, MOUSE_Y_POS}) - $signed({1'b0, ball_y_q});
  assign hit      = click && (state_q == ST_GAME) && in_box(dx) && in_box(dy);
  assign sec_tick = (state_q == ST_GAME) && (presc_q == PS_LAST);
  assign score_d  = hit ? bcd_inc_sat(score_q) : score_q;

`ifdef GAME_CTRL_BEST_SCORE_EN
  bcd2_t best_q;
  logic  new_best_q;
`endif

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      left_q     <= 1'b0;
      presc_q    <= '0;
      time_q     <= TIME_INIT;
      score_q    <= '0;
      ball_x_q   <= 10'(H_MAX / 2);
      ball_y_q   <= 10'(V_MAX / 2);
`ifdef GAME_CTRL_BEST_SCORE_EN
      best_q     <= '0;
      new_best_q <= 1'b0;
`endif
    end else begin
      left_q <= MOUSE_LEFT;
      if (state_q == ST_IDLE) begin
        if (click && start_hover) begin
          state_q    <= ST_GAME;
          score_q    <= '0;
          time_q     <= TIME_INIT;
          presc_q    <= '0;
          ball_x_q   <= next_x;
          ball_y_q   <= next_y;
`ifdef GAME_CTRL_BEST_SCORE_EN
          new_best_q <= 1'b0;
`endif
        end
      end else begin
        score_q <= score_d;
        if (hit) begin
          ball_x_q <= next_x;
          ball_y_q <= next_y;
        end
        if (sec_tick) begin
          presc_q <= '0;
          time_q  <= bcd_dec(time_q);
          // A hit on the final tick is already folded into score_d.
          if (time_q == TIME_ONE) begin
            state_q <= ST_IDLE;
`ifdef GAME_CTRL_BEST_SCORE_EN
            if (8'(score_d) > 8'(best_q)) begin
              best_q     <= score_d;
              new_best_q <= 1'b1;
            end
`endif
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  assign game_state = state_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign time_ten   = time_q.ten;
  assign time_one   = time_q.one;
  assign score_ten  = score_q.ten;
  assign score_one  = score_q.one;
`ifdef GAME_CTRL_BEST_SCORE_EN
  assign new_best   = new_best_q;
`else
  assign new_best   = 1'b0;
`endif
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: instance A (CLK_HZ=10, GAME_SEC=3) against a
// behavioural model, instance B (GAME_SEC=99) for saturation and placement range.
module tb_game_ctrl;
  localparam int          CLK_HZ = 10;
  localparam int          SEC    = 3;
  localparam int          BR     = 16;
  localparam logic [15:0] SEED   = 16'hACE1;
`ifdef GAME_CTRL_BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] mx, my, smx, smy;
  logic       left, hover, sleft, shover;
  logic       a_gs, a_nb, b_gs, b_nb;
  logic [9:0] a_bx, a_by, b_bx, b_by;
  logic [3:0] a_tt, a_to, a_st, a_so, b_tt, b_to, b_st, b_so;

  int vectors = 0;
  int fails   = 0;

  game_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SEC(SEC)) dut_a (
    .clk_25MHz(clk), .rst(rst), .MOUSE_X_POS(mx), .MOUSE_Y_POS(my),
    .MOUSE_LEFT(left), .start_hover(hover), .game_state(a_gs),
    .ball_x(a_bx), .ball_y(a_by), .time_ten(a_tt), .time_one(a_to),
    .score_ten(a_st), .score_one(a_so), .new_best(a_nb));

  game_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SEC(99)) dut_b (
    .clk_25MHz(clk), .rst(rst), .MOUSE_X_POS(smx), .MOUSE_Y_POS(smy),
    .MOUSE_LEFT(sleft), .start_hover(shover), .game_state(b_gs),
    .ball_x(b_bx), .ball_y(b_by), .time_ten(b_tt), .time_one(b_to),
    .score_ten(b_st), .score_one(b_so), .new_best(b_nb));

  // Behavioural model of instance A: integers for time/score, modulo placement.
  int          m_game, m_time, m_score, m_bx, m_by, m_presc, m_best, m_nb;
  logic [15:0] m_lfsr;
  logic        m_prev;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin : model
    int  px, py;
    bit  clk_ev, hit;
    if (rst) begin
      m_game = 0; m_time = SEC; m_score = 0; m_bx = 320; m_by = 240;
      m_presc = 0; m_best = 0; m_nb = 0; m_prev = 1'b0; m_lfsr = SEED;
    end else begin
      clk_ev = left && !m_prev;
      px = BR + (int'(m_lfsr[9:0]) % (640 - 2*BR));
      py = BR + (int'(m_lfsr[8:0]) % (480 - 2*BR));
      if (m_game == 0) begin
        if (clk_ev && hover) begin
          m_game = 1; m_score = 0; m_time = SEC; m_presc = 0; m_nb = 0;
          m_bx = px; m_by = py;
        end
      end else begin
        hit = clk_ev && iabs(int'(mx) - m_bx) <= BR && iabs(int'(my) - m_by) <= BR;
        if (hit) begin
          if (m_score < 99) m_score = m_score + 1;
          m_bx = px; m_by = py;
        end
        if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          m_time  = m_time - 1;
          if (m_time == 0) begin
            m_game = 0;
            if (BEST_EN && m_score > m_best) begin
              m_best = m_score; m_nb = 1;
            end
          end
        end else m_presc = m_presc + 1;
      end
      m_prev = left;
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end
  end

  function automatic logic [37:0] exp_vec();
    return {m_game[0], 10'(m_bx), 10'(m_by), 4'(m_time / 10), 4'(m_time % 10),
            4'(m_score / 10), 4'(m_score % 10), m_nb[0]};
  endfunction

  logic [37:0] a_vec;
  assign a_vec = {a_gs, a_bx, a_by, a_tt, a_to, a_st, a_so, a_nb};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_round();
    hover = 1'b1; left = 1'b1;
    tick();
    hover = 1'b0; left = 1'b0;
    tick();
  endtask

  task automatic click_ball();
    mx = 10'(m_bx); my = 10'(m_by); left = 1'b1;
    tick();
    left = 1'b0;
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1; left = 1'b0; hover = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (a_vec !== {1'b0, 10'd320, 10'd240, 8'h03, 8'h00, 1'b0}) begin
      fails++; $display("FAIL reset_state got=%h required=%h", a_vec, {1'b0, 10'd320, 10'd240, 8'h03, 8'h00, 1'b0});
    end
    vectors++;
    if ({b_gs, b_tt, b_to, b_st, b_so} !== {1'b0, 8'h99, 8'h00}) begin
      fails++; $display("FAIL reset_b got=%h required=%h", {b_gs, b_tt, b_to, b_st, b_so}, {1'b0, 8'h99, 8'h00});
    end
    rst = 1'b0;
  endtask

  task automatic test_round();
    hover = 1'b1; left = 1'b1;
    tick();
    hover = 1'b0; left = 1'b0;
    vectors++;
    if ({a_gs, a_tt, a_to, a_st, a_so} !== {1'b1, 8'h03, 8'h00}) begin
      fails++; $display("FAIL round_start got=%h required=%h", {a_gs, a_tt, a_to, a_st, a_so}, {1'b1, 8'h03, 8'h00});
    end
    for (int i = 1; i <= 30; i++) begin
      tick();
      vectors++;
      if (a_vec !== exp_vec()) begin
        fails++; $display("FAIL round_cyc%0d got=%h required=%h", i, a_vec, exp_vec());
      end
      if (i == 10) begin
        vectors++;
        if ({a_tt, a_to} !== 8'h02) begin
          fails++; $display("FAIL round_time10 got=%h required=02", {a_tt, a_to});
        end
      end
    end
    vectors++;
    if ({a_gs, a_tt, a_to} !== {1'b0, 8'h00}) begin
      fails++; $display("FAIL round_end got=%h required=000", {a_gs, a_tt, a_to});
    end
  endtask

  task automatic test_hit();
    pulse_rst();
    start_round();
    mx = 10'(m_bx + 16); my = 10'(m_by - 16); left = 1'b1;
    tick();
    left = 1'b0;
    vectors++;
    if ({a_st, a_so} !== 8'h01 || a_vec !== exp_vec()) begin
      fails++; $display("FAIL hit_corner got=%h required=%h", a_vec, exp_vec());
    end
    tick();
    mx = 10'(m_bx + 17); my = 10'(m_by); left = 1'b1;
    tick();
    left = 1'b0;
    vectors++;
    if ({a_st, a_so} !== 8'h01 || a_vec !== exp_vec()) begin
      fails++; $display("FAIL miss_x17 got=%h required=%h", a_vec, exp_vec());
    end
  endtask

  task automatic test_held();
    pulse_rst();
    start_round();
    mx = 10'(m_bx); my = 10'(m_by); left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (a_vec !== exp_vec()) begin
        fails++; $display("FAIL held_cyc%0d got=%h required=%h", i, a_vec, exp_vec());
      end
    end
    left = 1'b0;
    vectors++;
    if ({a_st, a_so} !== 8'h01) begin
      fails++; $display("FAIL held_one_hit got=%h required=01", {a_st, a_so});
    end
  endtask

  task automatic test_final_tick();
    int guard, sc;
    pulse_rst();
    start_round();
    guard = 0;
    while (!(m_presc == CLK_HZ - 1 && m_time == 1) && guard < 100) begin
      tick(); guard++;
    end
    vectors++;
    if (guard >= 100) begin
      fails++; $display("FAIL final_tick_wait got=timeout required=final_tick");
    end else begin
      sc = m_score + 1;
      mx = 10'(m_bx); my = 10'(m_by); left = 1'b1;
      tick();
      left = 1'b0;
      vectors++;
      if ({a_gs, a_tt, a_to, a_st, a_so} !== {1'b0, 8'h00, 4'(sc / 10), 4'(sc % 10)}) begin
        fails++; $display("FAIL final_tick_hit got=%h required=%h", {a_gs, a_tt, a_to, a_st, a_so}, {1'b0, 8'h00, 4'(sc / 10), 4'(sc % 10)});
      end
    end
  endtask

  task automatic test_rst_mid();
    pulse_rst();
    start_round();
    click_ball();
    vectors++;
    if ({a_st, a_so} !== 8'h01) begin
      fails++; $display("FAIL mid_hit got=%h required=01", {a_st, a_so});
    end
    pulse_rst();
    vectors++;
    if (a_vec !== {1'b0, 10'd320, 10'd240, 8'h03, 8'h00, 1'b0}) begin
      fails++; $display("FAIL mid_rst got=%h required=%h", a_vec, {1'b0, 10'd320, 10'd240, 8'h03, 8'h00, 1'b0});
    end
  endtask

  task automatic play_round(input int hits, input bit want_nb, input string nm);
    int guard;
    start_round();
    for (int i = 0; i < hits; i++) click_ball();
    guard = 0;
    while (m_game != 0 && guard < 100) begin
      tick(); guard++;
    end
    vectors++;
    if (a_gs !== 1'b0 || {a_st, a_so} !== {4'(hits / 10), 4'(hits % 10)} || a_nb !== want_nb) begin
      fails++; $display("FAIL %s got=%b/%h/%b required=0/%0d/%b", nm, a_gs, {a_st, a_so}, a_nb, hits, want_nb);
    end
  endtask

  task automatic test_best();
    pulse_rst();
    play_round(2, BEST_EN, "best_round1");
    play_round(1, 1'b0, "best_round2");
  endtask

  task automatic test_random();
    int ox, oy, vx, vy;
    pulse_rst();
    for (int i = 0; i < 400; i++) begin
      ox = int'($urandom_range(0, 40)) - 20;
      oy = int'($urandom_range(0, 40)) - 20;
      vx = m_bx + ox; vy = m_by + oy;
      if (vx < 0) vx = 0;
      if (vy < 0) vy = 0;
      mx = 10'(vx); my = 10'(vy);
      left  = ($urandom_range(0, 2) != 0);
      hover = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (a_vec !== exp_vec()) begin
        fails++; $display("FAIL random_cyc%0d got=%h required=%h", i, a_vec, exp_vec());
      end
    end
    rst = 1'b0; left = 1'b0; hover = 1'b0;
    tick();
  endtask

  task automatic range_check(input int n);
    vectors++;
    if (b_bx < 10'd16 || b_bx > 10'd623 || b_by < 10'd16 || b_by > 10'd463) begin
      fails++; $display("FAIL ball_range n=%0d got=(%0d,%0d) required=[16..623]x[16..463]", n, b_bx, b_by);
    end
  endtask

  task automatic test_sat_range();
    int reloc, k, rounds, guard, e;
    pulse_rst();
    reloc = 0; k = 0; rounds = 0; guard = 0;
    sleft = 1'b0; shover = 1'b0;
    while (reloc < 1000 && guard < 6000) begin
      if (b_gs == 1'b0) begin
        shover = 1'b1; sleft = 1'b1;
        tick();
        shover = 1'b0; sleft = 1'b0;
        reloc++; rounds++;
        range_check(reloc);
      end else begin
        smx = b_bx; smy = b_by; sleft = 1'b1;
        tick();
        sleft = 1'b0;
        reloc++;
        range_check(reloc);
        if (rounds == 1 && k < 100) begin
          k++;
          e = (k > 99) ? 99 : k;
          vectors++;
          if ({b_st, b_so} !== {4'(e / 10), 4'(e % 10)}) begin
            fails++; $display("FAIL sat_hit%0d got=%h required=%0d", k, {b_st, b_so}, e);
          end
        end
      end
      tick();
      guard += 2;
    end
    vectors++;
    if (reloc < 1000 || k != 100) begin
      fails++; $display("FAIL sat_progress got=reloc%0d/hits%0d required=1000/100", reloc, k);
    end
  endtask

  initial begin
    rst = 1'b1; mx = '0; my = '0; left = 1'b0; hover = 1'b0;
    smx = '0; smy = '0; sleft = 1'b0; shover = 1'b0;
    test_reset();
    test_round();
    test_hit();
    test_held();
    test_final_tick();
    test_rst_mid();
    test_best();
    test_random();
    test_sat_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
